// File: rtl/fl_ticket_splitter_mcast_pkg.sv
// Shared types and helpers for the multicast FrameLink ticket splitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fl_ticket_splitter_mcast_pkg;

  // Splitter control states; plain constants keep the encoding visible in waves.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t FWD  = 2'd1;
  localparam state_t DROP = 2'd2;

  // Steering modes.
  localparam int MODE_MASK = 0;
  localparam int MODE_RR   = 1;

  // Ceiling log2 for sizing pointers and counters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // REM width; a one-byte bus still gets a 1-bit field so slices stay legal.
  function automatic int rem_width(input int data_width);
    int r;
    r = clog2(data_width / 8);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fl_ticket_splitter_mcast_if.sv
// FrameLink ingress, N egress ports, ticket in/out and drop counter bundle.
// Latency: n/a (wiring only).
// Backpressure: active-low SRC/DST ready pairs, ticket VLD/RQ handshakes.
interface fl_ticket_splitter_mcast_if
  import fl_ticket_splitter_mcast_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int OUTPUT_COUNT = 4,
  parameter int TICKET_WIDTH = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int DREM_WIDTH   = rem_width(DATA_WIDTH)
);
  logic [DATA_WIDTH-1:0]                RX_DATA;
  logic [DREM_WIDTH-1:0]                RX_REM;
  logic                                 RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N;
  logic                                 RX_SRC_RDY_N, RX_DST_RDY_N;
  logic [TICKET_WIDTH-1:0]              CTRL_DATA_IN;
  logic [OUTPUT_COUNT-1:0]              CTRL_MASK_IN;
  logic                                 CTRL_DATA_IN_VLD, CTRL_DATA_IN_RQ;
  logic [OUTPUT_COUNT*DATA_WIDTH-1:0]   TX_DATA;
  logic [OUTPUT_COUNT*DREM_WIDTH-1:0]   TX_REM;
  logic [OUTPUT_COUNT-1:0]              TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N;
  logic [OUTPUT_COUNT-1:0]              TX_SRC_RDY_N, TX_DST_RDY_N;
  logic [OUTPUT_COUNT*TICKET_WIDTH-1:0] CTRL_DATA_OUT;
  logic [OUTPUT_COUNT-1:0]              CTRL_DATA_OUT_VLD, CTRL_DATA_OUT_RQ;
  logic [CNT_WIDTH-1:0]                 DROP_CNT;

  // Environment side: drives ingress, tickets and egress readiness.
  modport master (
    output RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N,
    input  RX_DST_RDY_N,
    output CTRL_DATA_IN, CTRL_MASK_IN, CTRL_DATA_IN_VLD,
    input  CTRL_DATA_IN_RQ,
    input  TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N,
    output TX_DST_RDY_N,
    input  CTRL_DATA_OUT, CTRL_DATA_OUT_VLD,
    output CTRL_DATA_OUT_RQ,
    input  DROP_CNT
  );

  // Splitter side.
  modport slave (
    input  RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N,
    output RX_DST_RDY_N,
    input  CTRL_DATA_IN, CTRL_MASK_IN, CTRL_DATA_IN_VLD,
    output CTRL_DATA_IN_RQ,
    output TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N,
    input  TX_DST_RDY_N,
    output CTRL_DATA_OUT, CTRL_DATA_OUT_VLD,
    input  CTRL_DATA_OUT_RQ,
    output DROP_CNT
  );
endinterface

// File: rtl/fl_ticket_splitter_mcast_fifo.sv
// First-word-fall-through register FIFO holding tickets for one output.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: push ignored while full, pop ignored while empty.
module fl_ticket_fifo
  import fl_ticket_splitter_mcast_pkg::*;
#(
  parameter int TICKET_WIDTH = 16,
  parameter int ITEMS        = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [TICKET_WIDTH-1:0] push_dat_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  output logic [TICKET_WIDTH-1:0] head_dat_o,
  output logic                    head_vld_o,
  output logic                    full_o
);
  localparam int AW = clog2(ITEMS);
  localparam int CW = AW + 1;

  logic [TICKET_WIDTH-1:0] mem_q [ITEMS];
  logic [AW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    do_push, do_pop;

  assign full_o     = (cnt_q == CW'(ITEMS));
  assign head_vld_o = (cnt_q != '0);
  assign head_dat_o = mem_q[rd_q];
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & head_vld_o;

  // Occupancy follows the qualified push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Pointers and count; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end
endmodule

// File: rtl/fl_ticket_splitter_mcast.sv
// Pairs each frame with a ticket and forwards it to a mask/round-robin set of outputs.
// Latency: zero-cycle data path; ticket taken in IDLE, so one bubble between frames.
// Backpressure: ingress stalls until every selected output is ready (lockstep).
module fl_ticket_splitter_mcast
  import fl_ticket_splitter_mcast_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int OUTPUT_COUNT      = 4,
  parameter int TICKET_WIDTH      = 16,
  parameter int TICKET_FIFO_ITEMS = 16,
  parameter int MODE              = MODE_MASK,
  parameter int CNT_WIDTH         = 16
) (
  input logic                       CLK,
  input logic                       RESET,
  fl_ticket_splitter_mcast_if.slave bus
);
  localparam int DREM_WIDTH = rem_width(DATA_WIDTH);
  localparam int RR_WIDTH   = clog2(OUTPUT_COUNT);

  state_t                  state_q, state_d;
  logic [OUTPUT_COUNT-1:0] target_q, target_d, target_sel;
  logic [RR_WIDTH-1:0]     rr_q, rr_d;
  logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;
  logic [OUTPUT_COUNT-1:0] fifo_full, fifo_vld;
  logic                    accept, xfer, rx_dst_rdy_n, fwd;

  // Candidate destination set for the ticket currently offered.
  always_comb begin
    target_sel = '0;
    if (MODE == MODE_RR) target_sel[rr_q] = 1'b1;
    else                 target_sel = bus.CTRL_MASK_IN;
  end

  // Full check uses registered flags, so a same-cycle pop never frees a slot.
  // No accept is signalled while reset is held.
  assign accept = (state_q == IDLE) & bus.CTRL_DATA_IN_VLD
                & ~|(target_sel & fifo_full) & ~RESET;
  assign bus.CTRL_DATA_IN_RQ = accept;
  assign fwd = (state_q == FWD);

  // Ingress readiness: closed in IDLE, lockstep OR in FWD, open sink in DROP.
  always_comb begin
    rx_dst_rdy_n = 1'b1;
    if (state_q == FWD)       rx_dst_rdy_n = |(bus.TX_DST_RDY_N & target_q);
    else if (state_q == DROP) rx_dst_rdy_n = 1'b0;
  end
  assign bus.RX_DST_RDY_N = rx_dst_rdy_n;
  assign xfer = ~bus.RX_SRC_RDY_N & ~rx_dst_rdy_n;

  // Frame sequencing, round-robin advance and drop accounting.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    rr_d       = rr_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        target_d = target_sel;
        state_d  = (|target_sel) ? FWD : DROP;
        if (MODE == MODE_RR)
          rr_d = (rr_q == RR_WIDTH'(OUTPUT_COUNT - 1)) ? '0 : rr_q + 1'b1;
      end
      FWD:  if (xfer && !bus.RX_EOF_N) state_d = IDLE;
      DROP: if (xfer && !bus.RX_EOF_N) begin
        state_d = IDLE;
        if (drop_cnt_q != {CNT_WIDTH{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset abandons any frame in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      target_q   <= '0;
      rr_q       <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      rr_q       <= rr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign bus.DROP_CNT = drop_cnt_q;

  // Data and delimiters fan out to every output; only SRC_RDY_N selects.
  always_comb begin
    for (int i = 0; i < OUTPUT_COUNT; i++) begin
      bus.TX_DATA[i*DATA_WIDTH +: DATA_WIDTH] = bus.RX_DATA;
      bus.TX_REM[i*DREM_WIDTH +: DREM_WIDTH]  = bus.RX_REM;
      bus.TX_SOF_N[i]     = bus.RX_SOF_N;
      bus.TX_EOF_N[i]     = bus.RX_EOF_N;
      bus.TX_SOP_N[i]     = bus.RX_SOP_N;
      bus.TX_EOP_N[i]     = bus.RX_EOP_N;
      bus.TX_SRC_RDY_N[i] = bus.RX_SRC_RDY_N | ~(fwd & target_q[i]);
    end
  end
  assign bus.CTRL_DATA_OUT_VLD = fifo_vld;

  for (genvar i = 0; i < OUTPUT_COUNT; i++) begin : g_fifo
    fl_ticket_fifo #(
      .TICKET_WIDTH (TICKET_WIDTH),
      .ITEMS        (TICKET_FIFO_ITEMS)
    ) u_fifo (
      .CLK        (CLK),
      .RESET      (RESET),
      .push_dat_i (bus.CTRL_DATA_IN),
      .push_i     (accept & target_sel[i]),
      .pop_i      (bus.CTRL_DATA_OUT_RQ[i]),
      .head_dat_o (bus.CTRL_DATA_OUT[i*TICKET_WIDTH +: TICKET_WIDTH]),
      .head_vld_o (fifo_vld[i]),
      .full_o     (fifo_full[i])
    );
  end
endmodule

// File: tb/tb_fl_ticket_splitter_mcast.sv
// Drives a mask-mode and a round-robin splitter against a queue-based reference.
// Latency: n/a.
// Backpressure: random per-output DST_RDY_N and source bubbles.
module tb_fl_ticket_splitter_mcast;
  logic clk = 1'b0;
  logic rst;
  logic sel;  // 0 = mask-mode DUT, 1 = round-robin DUT

  logic [63:0]  rx_data;
  logic [2:0]   rx_rem;
  logic         rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n;
  logic [15:0]  tkt;
  logic [3:0]   mask;
  logic         tkt_vld;
  logic [3:0]   tx_dst_rdy_n, out_rq;

  logic         rx_dst_rdy_n, tkt_rq;
  logic [255:0] tx_data;
  logic [11:0]  tx_rem;
  logic [3:0]   tx_sof_n, tx_eof_n, tx_src_rdy_n, out_vld;
  logic [63:0]  out_dat;
  logic [15:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq [8][$];  // expected tickets, index dut*4+output
  int          m_drop [2];
  int          m_rr   [2];

  always #5 clk = ~clk;

  fl_ticket_splitter_mcast_if #(.DATA_WIDTH(64), .OUTPUT_COUNT(4), .TICKET_WIDTH(16), .CNT_WIDTH(16)) if0 ();
  fl_ticket_splitter_mcast_if #(.DATA_WIDTH(64), .OUTPUT_COUNT(4), .TICKET_WIDTH(16), .CNT_WIDTH(16)) if1 ();

  fl_ticket_splitter_mcast #(.DATA_WIDTH(64), .OUTPUT_COUNT(4), .TICKET_WIDTH(16),
    .TICKET_FIFO_ITEMS(16), .MODE(0), .CNT_WIDTH(16)) u_dut_mask (.CLK(clk), .RESET(rst), .bus(if0));
  fl_ticket_splitter_mcast #(.DATA_WIDTH(64), .OUTPUT_COUNT(4), .TICKET_WIDTH(16),
    .TICKET_FIFO_ITEMS(16), .MODE(1), .CNT_WIDTH(16)) u_dut_rr (.CLK(clk), .RESET(rst), .bus(if1));

  assign if0.RX_DATA = rx_data;   assign if1.RX_DATA = rx_data;
  assign if0.RX_REM = rx_rem;     assign if1.RX_REM = rx_rem;
  assign if0.RX_SOF_N = rx_sof_n; assign if1.RX_SOF_N = rx_sof_n;
  assign if0.RX_EOF_N = rx_eof_n; assign if1.RX_EOF_N = rx_eof_n;
  assign if0.RX_SOP_N = rx_sop_n; assign if1.RX_SOP_N = rx_sop_n;
  assign if0.RX_EOP_N = rx_eop_n; assign if1.RX_EOP_N = rx_eop_n;
  assign if0.RX_SRC_RDY_N = sel ? 1'b1 : rx_src_rdy_n;
  assign if1.RX_SRC_RDY_N = sel ? rx_src_rdy_n : 1'b1;
  assign if0.CTRL_DATA_IN = tkt;  assign if1.CTRL_DATA_IN = tkt;
  assign if0.CTRL_MASK_IN = mask; assign if1.CTRL_MASK_IN = mask;
  assign if0.CTRL_DATA_IN_VLD = tkt_vld & ~sel;
  assign if1.CTRL_DATA_IN_VLD = tkt_vld & sel;
  assign if0.TX_DST_RDY_N = tx_dst_rdy_n;
  assign if1.TX_DST_RDY_N = tx_dst_rdy_n;
  assign if0.CTRL_DATA_OUT_RQ = sel ? 4'b0 : out_rq;
  assign if1.CTRL_DATA_OUT_RQ = sel ? out_rq : 4'b0;

  assign rx_dst_rdy_n = sel ? if1.RX_DST_RDY_N      : if0.RX_DST_RDY_N;
  assign tkt_rq       = sel ? if1.CTRL_DATA_IN_RQ   : if0.CTRL_DATA_IN_RQ;
  assign tx_data      = sel ? if1.TX_DATA           : if0.TX_DATA;
  assign tx_rem       = sel ? if1.TX_REM            : if0.TX_REM;
  assign tx_sof_n     = sel ? if1.TX_SOF_N          : if0.TX_SOF_N;
  assign tx_eof_n     = sel ? if1.TX_EOF_N          : if0.TX_EOF_N;
  assign tx_src_rdy_n = sel ? if1.TX_SRC_RDY_N      : if0.TX_SRC_RDY_N;
  assign out_vld      = sel ? if1.CTRL_DATA_OUT_VLD : if0.CTRL_DATA_OUT_VLD;
  assign out_dat      = sel ? if1.CTRL_DATA_OUT     : if0.CTRL_DATA_OUT;
  assign drop_cnt     = sel ? if1.DROP_CNT          : if0.DROP_CNT;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_rx_dst"}, rx_dst_rdy_n, 1'b1);
    chk({tag, "_rq"}, tkt_rq, 1'b0);
    chk({tag, "_tx_src"}, tx_src_rdy_n, 4'hf);
    chk({tag, "_vld"}, out_vld, 4'h0);
    chk({tag, "_drop"}, drop_cnt, 16'h0);
  endtask

  // Offer a ticket until accepted; expected destinations follow the steering rules.
  task automatic take_ticket(input logic [15:0] t, input logic [3:0] m,
                             output logic [3:0] tgt, output bit ok);
    int d = sel ? 1 : 0;
    ok = 1'b0;
    tkt = t; mask = m; tkt_vld = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (tkt_rq === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    tkt_vld = 1'b0;
    chk("ticket_taken", ok, 1'b1);
    tgt = d ? (4'b0001 << m_rr[d]) : m;
    if (ok) begin
      if (d == 1) m_rr[d] = (m_rr[d] + 1) % 4;
      for (int i = 0; i < 4; i++) if (tgt[i]) mq[d*4+i].push_back(t);
    end
  endtask

  // Stream n words; every cycle compare readiness and every transfer's payload.
  task automatic send_words(input logic [3:0] tgt, input int n, input bit rnd, input int stall2);
    int d = sel ? 1 : 0;
    int w = 0, c = 0, stl = stall2;
    logic exp_dst;
    bit xfer;
    while (w < n && c < 300) begin
      rx_data  = {$urandom, $urandom};
      rx_rem   = 3'($urandom);
      rx_sof_n = (w != 0);   rx_sop_n = (w != 0);
      rx_eof_n = (w != n-1); rx_eop_n = (w != n-1);
      xfer = 1'b0;
      while (!xfer && c < 300) begin
        rx_src_rdy_n = rnd && ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 4; i++) tx_dst_rdy_n[i] = rnd && ($urandom_range(0, 3) == 0);
        if (stl > 0) begin tx_dst_rdy_n[2] = 1'b1; stl--; end
        @(negedge clk);
        exp_dst = (tgt == 4'b0) ? 1'b0 : |(tx_dst_rdy_n & tgt);
        chk("rx_dst_rdy_n", rx_dst_rdy_n, exp_dst);
        for (int i = 0; i < 4; i++) begin
          if (tgt[i]) chk("tx_src_sel", tx_src_rdy_n[i], rx_src_rdy_n);
          else        chk("tx_src_idle", tx_src_rdy_n[i], 1'b1);
        end
        xfer = !rx_src_rdy_n && !exp_dst;
        if (xfer) begin
          for (int i = 0; i < 4; i++) if (tgt[i]) begin
            chk("tx_data", tx_data[i*64 +: 64], rx_data);
            chk("tx_rem", tx_rem[i*3 +: 3], rx_rem);
            chk("tx_sof", tx_sof_n[i], (w != 0));
            chk("tx_eof", tx_eof_n[i], (w != n-1));
          end
        end
        @(posedge clk); #1;
        c++;
      end
      w++;
    end
    chk("frame_in_budget", (c < 300), 1'b1);
    rx_src_rdy_n = 1'b1;
    tx_dst_rdy_n = 4'b0;
    if (tgt == 4'b0 && m_drop[d] < 65535) m_drop[d]++;
    @(negedge clk);
    chk("drop_cnt", drop_cnt, m_drop[d]);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [15:0] t, input logic [3:0] m, input int n,
                            input bit rnd, input int stall2);
    logic [3:0] tgt;
    bit ok;
    take_ticket(t, m, tgt, ok);
    if (ok) send_words(tgt, n, rnd, stall2);
  endtask

  // Pop every expected ticket in order, then poke an empty FIFO.
  task automatic drain();
    int d = sel ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      while (mq[d*4+i].size() > 0) begin
        @(negedge clk);
        chk("tkt_vld", out_vld[i], 1'b1);
        chk("tkt_dat", out_dat[i*16 +: 16], mq[d*4+i][0]);
        out_rq[i] = 1'b1;
        @(posedge clk); #1;
        out_rq[i] = 1'b0;
        void'(mq[d*4+i].pop_front());
      end
      @(negedge clk);
      chk("tkt_empty", out_vld[i], 1'b0);
      out_rq[i] = 1'b1;
      @(posedge clk); #1;
      out_rq[i] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tgt;
    bit ok;
    rst = 1'b1; sel = 1'b0;
    rx_data = '0; rx_rem = '0; rx_sof_n = 1'b1; rx_eof_n = 1'b1; rx_sop_n = 1'b1; rx_eop_n = 1'b1;
    rx_src_rdy_n = 1'b1; tkt = '0; mask = '0; tkt_vld = 1'b0; tx_dst_rdy_n = '0; out_rq = '0;
    m_drop[0] = 0; m_drop[1] = 0; m_rr[0] = 0; m_rr[1] = 0;
    #1;
    reset_values("rst_mask");
    sel = 1'b1; #1;
    reset_values("rst_rr");
    sel = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    // Multicast to outputs 0 and 2, then the same with output 2 stalled.
    send_frame(16'h1234, 4'b0101, 3, 1'b0, 0);
    @(negedge clk);
    chk("mc_fifo_vld", out_vld, 4'b0101);
    @(posedge clk); #1;
    drain();
    send_frame(16'h1234, 4'b0101, 3, 1'b0, 5);
    drain();

    // Empty mask drops the frame and bumps the counter.
    send_frame(16'hdead, 4'b0000, 4, 1'b0, 0);

    // Random masks, lengths and backpressure.
    for (int k = 0; k < 42; k++) begin
      send_frame(16'($urandom), 4'($urandom), $urandom_range(1, 5), 1'b1, 0);
      if (k % 6 == 5) drain();
    end
    drain();

    // Fill FIFO 1, then check the registered-full refusal and release.
    for (int k = 0; k < 16; k++) send_frame(16'h0100 + 16'(k), 4'b0010, 1, 1'b0, 0);
    tkt = 16'hbeef; mask = 4'b0010; tkt_vld = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("full_hold_rq", tkt_rq, 1'b0);
      @(posedge clk); #1;
    end
    out_rq[1] = 1'b1;
    @(negedge clk);
    chk("full_pop_rq", tkt_rq, 1'b0);
    chk("full_head", out_dat[31:16], mq[1][0]);
    @(posedge clk); #1;
    out_rq[1] = 1'b0;
    void'(mq[1].pop_front());
    @(negedge clk);
    chk("after_pop_rq", tkt_rq, 1'b1);
    @(posedge clk); #1;
    tkt_vld = 1'b0;
    mq[1].push_back(16'hbeef);
    send_words(4'b0010, 1, 1'b0, 0);
    drain();

    // Round-robin: six single-word frames land on 0,1,2,3,0,1.
    sel = 1'b1; #1;
    for (int k = 1; k <= 6; k++) send_frame(16'(k), 4'b0000, 1, 1'b0, 0);
    @(negedge clk);
    chk("rr_fifo_vld", out_vld, 4'b1111);
    chk("rr_head0", out_dat[15:0], 16'd1);
    chk("rr_head1", out_dat[31:16], 16'd2);
    @(posedge clk); #1;
    drain();
    for (int k = 0; k < 24; k++) begin
      send_frame(16'($urandom), 4'($urandom), $urandom_range(1, 4), 1'b1, 0);
      if (k % 8 == 7) drain();
    end
    drain();

    // Reset in the middle of a frame, then a clean frame afterwards.
    sel = 1'b0; #1;
    take_ticket(16'h0055, 4'b0001, tgt, ok);
    rx_data = 64'h1111; rx_rem = 3'd0; rx_sof_n = 1'b0; rx_sop_n = 1'b0;
    rx_eof_n = 1'b1; rx_eop_n = 1'b1; rx_src_rdy_n = 1'b0; tx_dst_rdy_n = 4'b0;
    @(negedge clk);
    chk("pre_rst_src", tx_src_rdy_n, 4'b1110);
    chk("pre_rst_vld", out_vld[0], 1'b1);
    @(posedge clk); #1;
    rx_data = 64'h2222; rx_sof_n = 1'b1; rx_sop_n = 1'b1;
    #1 rst = 1'b1;
    #1;
    reset_values("mid_rst");
    @(posedge clk); #2;
    rst = 1'b0;
    rx_src_rdy_n = 1'b1;
    for (int q = 0; q < 8; q++) mq[q].delete();
    m_drop[0] = 0; m_drop[1] = 0; m_rr[0] = 0; m_rr[1] = 0;
    @(posedge clk); #1;
    send_frame(16'h0077, 4'b0001, 3, 1'b0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
